// File: rtl/alu_disp_sel_pkg.sv
// Shared display package: page encodings, flag bit positions and small
// helpers used by the ALU display page selector.
package alu_disp_sel_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  // Display page encodings, in advance order
  localparam logic [1:0] PG_A    = 2'd0;
  localparam logic [1:0] PG_B    = 2'd1;
  localparam logic [1:0] PG_F    = 2'd2;
  localparam logic [1:0] PG_FLAG = 2'd3;

  // Bit positions of the ALU flags inside the 4-bit flags bus (MSB first)
  localparam int FLAG_ZF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_SF = 0;

  typedef logic [1:0] page_t;

  function automatic page_t next_page(input page_t pg);
    case (pg)
      PG_A:    return PG_B;
      PG_B:    return PG_F;
      PG_F:    return PG_FLAG;
      default: return PG_A;
    endcase
  endfunction

  // Flags shown right-aligned on the display, upper digits blank (zero)
  function automatic logic [DATA_W-1:0] flag_word(input logic [FLAG_W-1:0] fl);
    logic [DATA_W-1:0] w;
    w          = '0;
    w[FLAG_ZF] = fl[FLAG_ZF];
    w[FLAG_CF] = fl[FLAG_CF];
    w[FLAG_OF] = fl[FLAG_OF];
    w[FLAG_SF] = fl[FLAG_SF];
    return w;
  endfunction

endpackage

// File: rtl/alu_disp_sel_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debounce and a
// single-cycle pulse on each accepted press.
//
// After reset the button must first be seen released (stable low for
// DEB_CYCLES) before presses are honoured, so a button held down through
// reset never produces a pulse on reset release.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             armed;
  logic             level;
  logic             level_d;
  logic             differs;
  logic [CNT_W-1:0] cnt;

  // Before arming we wait for a stable release; afterwards for a stable change
  assign differs = armed ? (sync_p1 != level) : ~sync_p1;

  // Synchronise the raw button into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive differing cycles; accept once the count completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      armed <= 1'b0;
    end else if (!differs) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      if (armed) level <= sync_p1;
      else       armed <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed accepted level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/alu_disp_sel.sv
// ALU display page selector: two debounced buttons step through the
// operand/result/flag pages and freeze the word sent to the 7-seg driver.
module alu_disp_sel
  import alu_disp_sel_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_page,
  input  logic              btn_hold,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] F,
  input  logic [FLAG_W-1:0] flags,
  output logic [DATA_W-1:0] Data,
  output logic [1:0]        page,
  output logic              held
);

  logic              page_pls;
  logic              hold_pls;
  logic              reload;
  logic [DATA_W-1:0] src;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_page (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_page),
    .pulse (page_pls)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_hold),
    .pulse (hold_pls)
  );

  // Source word selected by the current (registered) page
  always_comb begin
    src = '0;
    case (page)
      PG_A:    src = A;
      PG_B:    src = B;
      PG_F:    src = F;
      default: src = flag_word(flags);
    endcase
  end

  // Page FSM and freeze toggle; a simultaneous page pulse loses to hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page   <= PG_A;
      held   <= 1'b0;
      reload <= 1'b0;
    end else begin
      reload <= 1'b0;
      if (hold_pls) begin
        held <= ~held;
      end else if (page_pls) begin
        page   <= next_page(page);
        reload <= held;
      end
    end
  end

  // Display word: live while not held, one-shot refresh after a held page change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  Data <= '0;
    else if (!held || reload) Data <= src;
  end

endmodule

// File: tb/tb_alu_disp_sel.sv
module tb_alu_disp_sel;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_page;
  logic        btn_hold;
  logic [31:0] A, B, F;
  logic [3:0]  flags;
  logic [31:0] Data;
  logic [1:0]  page;
  logic        held;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_disp_sel #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_page (btn_page),
    .btn_hold (btn_hold),
    .A        (A),
    .B        (B),
    .F        (F),
    .flags    (flags),
    .Data     (Data),
    .page     (page),
    .held     (held)
  );

  typedef struct {
    logic        press;
    logic [31:0] a, b, f;
    logic [3:0]  fl;
    logic [1:0]  ep;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [13];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // which: 0 = page, 1 = hold, 2 = both together
  task automatic press(input int which);
    if (which != 1) btn_page = 1'b1;
    if (which != 0) btn_hold = 1'b1;
    tick(10);
    btn_page = 1'b0;
    btn_hold = 1'b0;
    tick(10);
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'h12345678, 32'hBBBB0001, 32'hF0F00001, 4'b1010, 2'd2, 32'hF0F00001};
    vt[1]  = '{1'b1, 32'h12345678, 32'hBBBB0001, 32'hF0F00001, 4'b1010, 2'd3, 32'h0000000A};
    vt[2]  = '{1'b1, 32'h12345678, 32'hBBBB0001, 32'hF0F00001, 4'b1010, 2'd0, 32'h12345678};
    vt[3]  = '{1'b0, 32'hDEADBEEF, 32'hBBBB0001, 32'hF0F00001, 4'b1010, 2'd0, 32'hDEADBEEF};
    vt[4]  = '{1'b1, 32'hDEADBEEF, 32'hBBBB0001, 32'hF0F00001, 4'b1010, 2'd1, 32'hBBBB0001};
    vt[5]  = '{1'b0, 32'hDEADBEEF, 32'hCAFE0002, 32'hF0F00001, 4'b1010, 2'd1, 32'hCAFE0002};
    vt[6]  = '{1'b1, 32'hDEADBEEF, 32'hCAFE0002, 32'hF0F00001, 4'b1010, 2'd2, 32'hF0F00001};
    vt[7]  = '{1'b0, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b1010, 2'd2, 32'h00000005};
    vt[8]  = '{1'b1, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b0001, 2'd3, 32'h00000001};
    vt[9]  = '{1'b0, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b1111, 2'd3, 32'h0000000F};
    vt[10] = '{1'b1, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b1111, 2'd0, 32'hDEADBEEF};
    vt[11] = '{1'b1, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b1111, 2'd1, 32'hCAFE0002};
    vt[12] = '{1'b1, 32'hDEADBEEF, 32'hCAFE0002, 32'h00000005, 4'b1111, 2'd2, 32'h00000005};

    // Reset behaviour
    rst = 1'b1; btn_page = 1'b0; btn_hold = 1'b0;
    A = 32'h12345678; B = 32'hBBBB0001; F = 32'hF0F00001; flags = 4'b1010;
    tick(2);
    chk("rst_data", Data, 32'h0);
    chk("rst_page", {30'd0, page}, 32'd0);
    chk("rst_held", {31'd0, held}, 32'd0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_data", Data, 32'h12345678);
    chk("post_rst_page", {30'd0, page}, 32'd0);
    tick(8);

    // Long press gives exactly one advance
    press(0);
    chk("long_press_page", {30'd0, page}, 32'd1);
    chk("long_press_data", Data, 32'hBBBB0001);

    // Bouncing input never settles long enough
    for (int i = 0; i < 10; i++) begin
      btn_page = ~btn_page;
      tick(2);
    end
    btn_page = 1'b0;
    tick(10);
    chk("bounce_page", {30'd0, page}, 32'd1);

    // Table-driven page walk and source latency
    for (int i = 0; i < 13; i++) begin
      A = vt[i].a; B = vt[i].b; F = vt[i].f; flags = vt[i].fl;
      if (vt[i].press) press(0);
      else             tick(1);
      chk($sformatf("vec%0d_page", i), {30'd0, page}, {30'd0, vt[i].ep});
      chk($sformatf("vec%0d_data", i), Data, vt[i].ed);
    end

    // Freeze on page F, source changes ignored
    press(1);
    chk("hold_on", {31'd0, held}, 32'd1);
    F = 32'h9;
    tick(3);
    chk("hold_frozen", Data, 32'h5);
    btn_hold = 1'b1;
    begin
      int n = 0;
      while (held !== 1'b0 && n < 20) begin
        tick(1);
        n++;
      end
    end
    chk("unhold_seen", {31'd0, held}, 32'd0);
    chk("unhold_same_edge", Data, 32'h5);
    tick(1);
    chk("unhold_next_edge", Data, 32'h9);
    btn_hold = 1'b0;
    tick(10);

    // Page change while held loads the new page once, then freezes
    press(1);
    chk("hold2_on", {31'd0, held}, 32'd1);
    flags = 4'b1100;
    press(0);
    chk("held_adv_page", {30'd0, page}, 32'd3);
    chk("held_adv_data", Data, 32'h0000000C);
    flags = 4'b0011;
    tick(2);
    chk("held_adv_frozen", Data, 32'h0000000C);
    press(1);
    chk("hold2_off", {31'd0, held}, 32'd0);
    chk("hold2_off_data", Data, 32'h00000003);

    // Simultaneous pulses: hold wins, page pulse dropped
    press(2);
    chk("both_held", {31'd0, held}, 32'd1);
    chk("both_page", {30'd0, page}, 32'd3);

    // Reset mid-press: async clear, no pulse after release
    btn_page = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", Data, 32'h0);
    chk("async_rst_page", {30'd0, page}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    btn_page = 1'b0;
    tick(10);
    chk("rst_press_page", {30'd0, page}, 32'd0);
    chk("rst_press_held", {31'd0, held}, 32'd0);
    press(0);
    chk("after_rst_press", {30'd0, page}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
